// File: rtl/snow64_mem_burst_sequencer_pkg.sv
// rtl/snow64_mem_burst_sequencer_pkg.sv - state encoding and line geometry for the burst sequencer
package PkgSnow64MemBurstSeq;

  typedef enum logic {
    StIdle = 1'b0,
    StXfer = 1'b1
  } State;

  localparam int NUM_BEATS     = 4;
  localparam int BEAT_IDX_W    = 2;
  localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/snow64_memory_bus_guard_pkg.sv
// rtl/snow64_memory_bus_guard_pkg.sv - memory bus guard types shared with the burst sequencer
package PkgSnow64MemoryBusGuard;

  typedef enum logic {
    MatRead  = 1'b0,
    MatWrite = 1'b1
  } MemAccessType;

endpackage

// File: rtl/snow64_mem_burst_sequencer.sv
// rtl/snow64_mem_burst_sequencer.sv - moves one 256-bit line as four 64-bit beats on the external bus
module snow64_mem_burst_sequencer
  import PkgSnow64MemBurstSeq::*;
  import PkgSnow64MemoryBusGuard::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LINE_WIDTH-1:0] in_data,
  input  logic                  in_mem_acc_type,
  output logic                  out_busy,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  out_bus_req,
  output logic                  out_bus_we,
  output logic [ADDR_WIDTH-1:0] out_bus_addr,
  output logic [BEAT_WIDTH-1:0] out_bus_wdata,
  input  logic                  in_bus_ack,
  input  logic [BEAT_WIDTH-1:0] in_bus_rdata
);

  localparam int BYTE_OFF_W = LINE_OFFSET_W - BEAT_IDX_W;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NUM_BEATS - 1);

  State                  r_state;
  logic [BEAT_IDX_W-1:0] r_beat;
  logic [LINE_WIDTH-1:0] r_line;
  MemAccessType          r_acc_type;
  logic                  r_bus_req;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [BEAT_WIDTH-1:0] r_bus_wdata;
  logic [LINE_WIDTH-1:0] r_data;

  logic [BEAT_IDX_W-1:0] w_next_beat;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic                  w_unused_addr_bits;

  // Offset bits inside the line are dropped; beat index becomes addr[4:3].
  assign w_line_addr        = {in_addr[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  assign w_unused_addr_bits = ^in_addr[LINE_OFFSET_W-1:0];
  assign w_next_beat        = r_beat + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      r_line      <= '0;
      r_acc_type  <= MatRead;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_data      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_req) begin
            r_state     <= StXfer;
            r_beat      <= '0;
            r_line      <= in_data;
            r_acc_type  <= MemAccessType'(in_mem_acc_type);
            r_bus_req   <= 1'b1;
            r_bus_addr  <= w_line_addr;
            r_bus_wdata <= in_data[BEAT_WIDTH-1:0];
          end
        end
        StXfer: begin
          if (r_bus_req && in_bus_ack) begin
            if (r_acc_type == MatRead) begin
              r_data[BEAT_WIDTH*r_beat +: BEAT_WIDTH] <= in_bus_rdata;
            end
            if (r_beat == LAST_BEAT) begin
              r_bus_req <= 1'b0;
              r_state   <= StIdle;
            end else begin
              // Rebuild the low bits from the beat index so stepping never carries out of the line.
              r_beat      <= w_next_beat;
              r_bus_addr  <= {r_bus_addr[ADDR_WIDTH-1:LINE_OFFSET_W], w_next_beat, {BYTE_OFF_W{1'b0}}};
              r_bus_wdata <= r_line[BEAT_WIDTH*w_next_beat +: BEAT_WIDTH];
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_busy      = (r_state == StXfer) | ((r_state == StIdle) & in_req);
  assign out_data      = r_data;
  assign out_bus_req   = r_bus_req;
  assign out_bus_we    = (r_acc_type == MatWrite);
  assign out_bus_addr  = r_bus_addr;
  assign out_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_snow64_mem_burst_sequencer.sv
// tb/tb_snow64_mem_burst_sequencer.sv - directed self-checking bench for the burst sequencer
module tb_snow64_mem_burst_sequencer;

  logic         clk;
  logic         rst;
  logic         in_req;
  logic [63:0]  in_addr;
  logic [255:0] in_data;
  logic         in_mem_acc_type;
  logic         out_busy;
  logic [255:0] out_data;
  logic         out_bus_req;
  logic         out_bus_we;
  logic [63:0]  out_bus_addr;
  logic [63:0]  out_bus_wdata;
  logic         in_bus_ack;
  logic [63:0]  in_bus_rdata;

  int n_checks;
  int n_fails;

  snow64_mem_burst_sequencer #(
    .LINE_WIDTH(256),
    .ADDR_WIDTH(64),
    .BEAT_WIDTH(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_req         (in_req),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_mem_acc_type(in_mem_acc_type),
    .out_busy       (out_busy),
    .out_data       (out_data),
    .out_bus_req    (out_bus_req),
    .out_bus_we     (out_bus_we),
    .out_bus_addr   (out_bus_addr),
    .out_bus_wdata  (out_bus_wdata),
    .in_bus_ack     (in_bus_ack),
    .in_bus_rdata   (in_bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge with the DUT idle.
  task automatic run_access(input string tag, input logic [63:0] addr, input logic wr,
                            input logic [255:0] wline, input logic [255:0] rline,
                            input int stall_beat, input int stall_n, input logic poke,
                            input logic [255:0] exp_data);
    logic [63:0] base;
    int          busy_cnt;
    base     = {addr[63:5], 5'b0};
    busy_cnt = 0;
    in_req          = 1'b1;
    in_addr         = addr;
    in_data         = wline;
    in_mem_acc_type = wr;
    in_bus_ack      = 1'b0;
    #1;
    expect_eq({tag, "_busy_comb"}, 256'(out_busy), 256'(1));
    step();
    in_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_eq($sformatf("%s_req%0d", tag, k), 256'(out_bus_req), 256'(1));
      expect_eq($sformatf("%s_we%0d", tag, k), 256'(out_bus_we), 256'(wr));
      expect_eq($sformatf("%s_addr%0d", tag, k), 256'(out_bus_addr), 256'(base + 64'(k * 8)));
      if (wr) expect_eq($sformatf("%s_wdata%0d", tag, k), 256'(out_bus_wdata), 256'(wline[k*64 +: 64]));
      if (k == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          in_bus_ack = 1'b0;
          in_req     = poke;
          in_addr    = 64'hDEAD_BEEF_0000_00E0;
          in_data    = ~wline;
          if (out_busy) busy_cnt++;
          step();
          in_req = 1'b0;
          expect_eq($sformatf("%s_stall_req%0d", tag, s), 256'(out_bus_req), 256'(1));
          expect_eq($sformatf("%s_stall_addr%0d", tag, s), 256'(out_bus_addr), 256'(base + 64'(k * 8)));
          expect_eq($sformatf("%s_stall_wdata%0d", tag, s), 256'(out_bus_wdata), 256'(wr ? wline[k*64 +: 64] : 64'(out_bus_wdata)));
        end
      end
      in_bus_ack   = 1'b1;
      in_bus_rdata = rline[k*64 +: 64];
      if (out_busy) busy_cnt++;
      step();
      in_bus_ack = 1'b0;
    end
    expect_eq({tag, "_busy_end"}, 256'(out_busy), 256'(0));
    expect_eq({tag, "_req_end"}, 256'(out_bus_req), 256'(0));
    expect_eq({tag, "_busy_len"}, 256'(busy_cnt), 256'(4 + stall_n));
    expect_eq({tag, "_data"}, out_data, exp_data);
  endtask

  localparam logic [255:0] RLINE1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WLINE  = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  localparam logic [255:0] RLINE3 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                     64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    rst             = 1'b1;
    in_req          = 1'b0;
    in_addr         = '0;
    in_data         = '0;
    in_mem_acc_type = 1'b0;
    in_bus_ack      = 1'b0;
    in_bus_rdata    = '0;
    #1;
    expect_eq("rst_busy", 256'(out_busy), 256'(0));
    expect_eq("rst_req", 256'(out_bus_req), 256'(0));
    expect_eq("rst_we", 256'(out_bus_we), 256'(0));
    expect_eq("rst_addr", 256'(out_bus_addr), 256'(0));
    expect_eq("rst_wdata", 256'(out_bus_wdata), 256'(0));
    expect_eq("rst_data", out_data, 256'(0));
    step();
    rst = 1'b0;
    step();

    run_access("rd1", 64'h0000_0000_1000_0013, 1'b0, 256'(0), RLINE1, -1, 0, 1'b0, RLINE1);

    run_access("wr", 64'h0000_0000_2000_0020, 1'b1, WLINE, {256{1'b1}}, 2, 2, 1'b1, RLINE1);

    in_bus_ack   = 1'b1;
    in_bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    step();
    expect_eq("spur_req", 256'(out_bus_req), 256'(0));
    expect_eq("spur_busy", 256'(out_busy), 256'(0));
    expect_eq("spur_addr", 256'(out_bus_addr), 256'(64'h0000_0000_2000_0038));
    expect_eq("spur_data", out_data, RLINE1);
    in_bus_ack = 1'b0;

    in_req          = 1'b1;
    in_addr         = 64'h0000_0000_3000_0040;
    in_mem_acc_type = 1'b0;
    step();
    in_req       = 1'b0;
    in_bus_ack   = 1'b1;
    in_bus_rdata = 64'h5555_5555_5555_5555;
    step();
    step();
    expect_eq("mid_addr_beat2", 256'(out_bus_addr), 256'(64'h0000_0000_3000_0050));
    #2;
    rst = 1'b1;
    #1;
    expect_eq("mid_rst_req", 256'(out_bus_req), 256'(0));
    expect_eq("mid_rst_busy", 256'(out_busy), 256'(0));
    expect_eq("mid_rst_data", out_data, 256'(0));
    in_bus_ack = 1'b0;
    step();
    rst = 1'b0;
    step();

    run_access("rd_hi", 64'hFFFF_FFFF_FFFF_FFE7, 1'b0, 256'(0), RLINE3, 1, 1, 1'b0, RLINE3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
